// File: rtl/cpu_step_pkg.sv
// Shared types for the MIPS core execution controller.
// Mode encodings match the DE2 switch positions.
package cpu_step_pkg;

  typedef enum logic [1:0] {
    STEP  = 2'b00,
    RUN   = 2'b01,
    BURST = 2'b10,
    HALT  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    HOLD,
    IDLE,
    RUN_S,
    BURST_S
  } state_e;

  localparam int CNT_W = 32;

endpackage

// File: rtl/cpu_step_ctrl_key_debounce.sv
// Push-button synchroniser and debouncer.
// Emits a one-cycle press pulse on each debounced 1->0 edge.
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
        press_d  = stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution controller: core reset sequencing, run/step/burst
// clock-enable generation and a retired-cycle counter.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int DEB_CYCLES  = 500000,
  parameter int HOLD_CYCLES = 4,
  parameter int BURST_W     = 16
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               key_step_n,
  input  logic [1:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               core_rst_req,
  output logic               cpu_en,
  output logic               cpu_rst,
  output logic               busy,
  output logic [31:0]        cycle_count
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_e             state_q, state_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               en_q, en_d;
  logic               rst_q, rst_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               press;
  mode_e              md;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk_i  (CLOCK_50),
    .rst_i  (RESET),
    .key_n_i(key_step_n),
    .press_o(press)
  );

  assign md = mode_e'(mode);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    burst_d = burst_q;
    en_d    = 1'b0;
    rst_d   = 1'b0;
    if (core_rst_req) begin
      state_d = HOLD;
      hold_d  = HOLD_LAST;
      rst_d   = 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_q == '0) begin
            state_d = IDLE;
          end else begin
            hold_d = hold_q - 1'b1;
            rst_d  = 1'b1;
          end
        end
        IDLE: begin
          unique case (1'b1)
            md == STEP: en_d = press;
            md == RUN: begin
              state_d = RUN_S;
              en_d    = 1'b1;
            end
            md == BURST: begin
              if (press && burst_len != '0) begin
                state_d = BURST_S;
                burst_d = burst_len - 1'b1;
                en_d    = 1'b1;
              end
            end
            default: ;
          endcase
        end
        RUN_S: begin
          if (md == RUN) en_d = 1'b1;
          else state_d = IDLE;
        end
        BURST_S: begin
          if (burst_q == '0) begin
            state_d = IDLE;
          end else begin
            burst_d = burst_q - 1'b1;
            en_d    = 1'b1;
          end
        end
        default: begin
          state_d = HOLD;
          hold_d  = HOLD_LAST;
          rst_d   = 1'b1;
        end
      endcase
    end
  end

  // Counter lags cpu_en by one edge; any entry into HOLD clears it.
  always_comb begin
    busy_d = (state_d != IDLE);
    cnt_d  = cnt_q;
    if (state_d == HOLD) cnt_d = '0;
    else if (en_q) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= HOLD;
      hold_q  <= HOLD_LAST;
      burst_q <= '0;
      en_q    <= 1'b0;
      rst_q   <= 1'b1;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      burst_q <= burst_d;
      en_q    <= en_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_en      = en_q;
  assign cpu_rst     = rst_q;
  assign busy        = busy_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with short debounce and hold.
// Outputs are sampled 1 time unit after each rising edge.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_n = 1'b1;
  logic [1:0]  mode = 2'b11;
  logic [7:0]  blen = 8'd0;
  logic        req = 1'b0;
  logic        cpu_en, cpu_rst, busy;
  logic [31:0] cyc;

  int total = 0;
  int bad = 0;
  int en_seen = 0;
  int run_cur = 0;
  int run_max = 0;

  cpu_step_ctrl #(
    .DEB_CYCLES (4),
    .HOLD_CYCLES(3),
    .BURST_W    (8)
  ) dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .key_step_n  (key_n),
    .mode        (mode),
    .burst_len   (blen),
    .core_rst_req(req),
    .cpu_en      (cpu_en),
    .cpu_rst     (cpu_rst),
    .busy        (busy),
    .cycle_count (cyc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cpu_en) begin
      en_seen++;
      run_cur++;
      if (run_cur > run_max) run_max = run_cur;
    end else begin
      run_cur = 0;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    en_seen = 0;
    run_cur = 0;
    run_max = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_cyc", cyc, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    check("hold0", 32'(cpu_rst), 32'd1);
    tick();
    check("hold1", 32'(cpu_rst), 32'd1);
    tick();
    check("hold2", 32'(cpu_rst), 32'd1);
    tick();
    check("hold3", 32'(cpu_rst), 32'd0);
    check("hold_en", 32'(cpu_en), 32'd0);
    check("hold_cyc", cyc, 32'd0);
    tick();

    mode = 2'b00;
    clr();
    key_n = 1'b0;
    ticks(2);
    key_n = 1'b1;
    ticks(1);
    key_n = 1'b0;
    ticks(7);
    key_n = 1'b1;
    ticks(12);
    check("step_pulses", 32'(en_seen), 32'd1);
    check("step_width", 32'(run_max), 32'd1);
    check("step_cyc", cyc, 32'd1);

    clr();
    key_n = 1'b0;
    ticks(3);
    key_n = 1'b1;
    ticks(10);
    check("blip_pulses", 32'(en_seen), 32'd0);
    check("blip_cyc", cyc, 32'd1);

    mode = 2'b10;
    blen = 8'd5;
    clr();
    key_n = 1'b0;
    ticks(6);
    key_n = 1'b1;
    ticks(20);
    check("b5_pulses", 32'(en_seen), 32'd5);
    check("b5_run", 32'(run_max), 32'd5);
    check("b5_cyc", cyc, 32'd6);
    check("b5_busy", 32'(busy), 32'd0);

    blen = 8'd12;
    clr();
    key_n = 1'b0;
    ticks(5);
    key_n = 1'b1;
    ticks(5);
    mode = 2'b11;
    key_n = 1'b0;
    ticks(5);
    key_n = 1'b1;
    ticks(20);
    check("b12_pulses", 32'(en_seen), 32'd12);
    check("b12_run", 32'(run_max), 32'd12);
    check("b12_cyc", cyc, 32'd18);

    mode = 2'b10;
    blen = 8'd0;
    clr();
    key_n = 1'b0;
    ticks(6);
    key_n = 1'b1;
    ticks(12);
    check("b0_pulses", 32'(en_seen), 32'd0);
    check("b0_busy", 32'(busy), 32'd0);
    check("b0_cyc", cyc, 32'd18);

    mode = 2'b01;
    clr();
    ticks(20);
    check("run_pulses", 32'(en_seen), 32'd20);
    check("run_last", 32'(cpu_en), 32'd1);
    mode = 2'b11;
    tick();
    check("run_drop", 32'(cpu_en), 32'd0);
    ticks(2);
    check("run_cyc", cyc, 32'd38);
    check("run_busy", 32'(busy), 32'd0);

    mode = 2'b10;
    blen = 8'd200;
    clr();
    key_n = 1'b0;
    ticks(6);
    key_n = 1'b1;
    for (int i = 0; i < 60 && en_seen < 7; i++) tick();
    check("b200_run", 32'(en_seen), 32'd7);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("abort_en", 32'(cpu_en), 32'd0);
    check("abort_rst1", 32'(cpu_rst), 32'd1);
    check("abort_cyc", cyc, 32'd0);
    tick();
    check("abort_rst2", 32'(cpu_rst), 32'd1);
    tick();
    check("abort_rst3", 32'(cpu_rst), 32'd1);
    tick();
    check("abort_rst4", 32'(cpu_rst), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    ticks(3);
    check("abort_idle_en", 32'(cpu_en), 32'd0);

    mode = 2'b11;
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cnt_q;
    mode = 2'b01;
    tick();
    check("wrap0", cyc, 32'hFFFF_FFFE);
    tick();
    check("wrap1", cyc, 32'hFFFF_FFFF);
    tick();
    check("wrap2", cyc, 32'd0);
    mode = 2'b11;
    tick();
    check("wrap3", cyc, 32'd1);
    check("wrap_en", 32'(cpu_en), 32'd0);

    mode = 2'b01;
    ticks(2);
    check("arst_pre", 32'(cpu_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_en", 32'(cpu_en), 32'd0);
    check("arst_rst", 32'(cpu_rst), 32'd1);
    check("arst_busy", 32'(busy), 32'd1);
    check("arst_cyc", cyc, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Execution controller for the single-cycle MIPS core on the DE2 board. It sits between the board inputs (KEY, SW) and the core's clock-enable and reset, and replaces driving the processor clock directly from a key. It debounces the push-buttons, sequences a multi-cycle core reset, and lets the core run freely, single-step, or execute a programmable burst of N instructions. It also maintains a retired-cycle counter for display on the HEX digits.

## Interface
- DEB_CYCLES, 500000: consecutive stable samples required before a debounced level changes (10 ms at 50 MHz).
- HOLD_CYCLES, 4: cycles `cpu_rst` is held high on entry to HOLD; minimum 1.
- BURST_W, 16: width of `burst_len`.
- CLOCK_50  in  1  system clock; all logic runs on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- key_step_n  in  1  raw step push-button, active-low and asynchronous to the clock.
- mode  in  2  00 STEP, 01 RUN, 10 BURST, 11 HALT; sampled every cycle.
- burst_len  in  BURST_W  instruction count, sampled when a burst starts.
- core_rst_req  in  1  synchronous level request to re-reset the core.
- cpu_en  out  1  clock-enable to the core; one high cycle executes one instruction.
- cpu_rst  out  1  reset to the core (PC to start of instruction memory).
- busy  out  1  high in HOLD, RUN and BURST.
- cycle_count  out  32  number of cycles in which `cpu_en` was high.

## Operation
- **Reset values.** While RESET is high: state HOLD, `cpu_rst`=1, `cpu_en`=0, `busy`=1, `cycle_count`=0, and the debouncer's stable level = 1 (released).
- **Debounce path.** Two-flop synchroniser, then a counter.
  - If the synchronised level differs from the stable level, the counter increments.
  - When the counter reaches DEB_CYCLES-1, the stable level takes the new value and the counter clears.
  - If the levels are equal, the counter clears.
  - `press` is a one-cycle pulse on each stable 1→0 transition.
- **HOLD.** `cpu_rst`=1 and `cpu_en`=0 for HOLD_CYCLES cycles, then go to IDLE. `cycle_count` clears on entry.
- **IDLE.** `cpu_rst`=0. Action depends on `mode`:
  - STEP: on `press`, `cpu_en`=1 for exactly one cycle; remain in IDLE.
  - RUN: go to RUN.
  - BURST: on `press`, latch `burst_len`. If it is 0, do nothing. Otherwise go to BURST.
  - HALT: no action.
- **RUN.** `cpu_en`=1 every cycle while `mode`=RUN. Any other mode returns to IDLE, and `cpu_en` drops on the same edge.
- **BURST.** `cpu_en`=1 for exactly the latched count of cycles, then return to IDLE.
  - Mode changes and presses during a burst are ignored; the burst always completes.
- **core_rst_req.** Highest priority from every state. It forces HOLD and restarts the hold count. A burst in progress is aborted and `cpu_en` goes to 0 on the next edge. While the request stays high, the block remains in HOLD.
- **cycle_count.** Increments on each cycle with `cpu_en`=1 and wraps from 0xFFFFFFFF to 0.
- **Output registering.** All outputs are registered; nothing is combinational from inputs.

## Timing
- Raw key edge to `press`: 2 synchroniser cycles plus DEB_CYCLES stable cycles.
- STEP: `press` in cycle t gives `cpu_en` high in cycle t+1 only.
- RUN: `mode`=RUN sampled at edge t gives `cpu_en` high from t+1. Leaving RUN at edge t gives `cpu_en` low from t+1.
- BURST: `press` in cycle t gives `cpu_en` high in cycles t+1 … t+N, and `busy` low from t+N+1.
- Hold: RESET release or `core_rst_req` sampled gives `cpu_rst` high for HOLD_CYCLES cycles. `cpu_en` can first be asserted 1 cycle after `cpu_rst` falls.
- RESET mid-operation: all outputs return to their reset values immediately (asynchronous).

## Structure
- Package `cpu_step_pkg`:
  - enum `mode_e` (STEP, RUN, BURST, HALT);
  - enum `state_e` (HOLD, IDLE, RUN_S, BURST_S);
  - constant `CNT_W`=32.
- Sub-module `key_debounce`: synchroniser, counter, stable level and `press` pulse; parameter DEB_CYCLES; same clock and reset.
- Top level holds the FSM, hold counter, burst down-counter and `cycle_count`.

## Test plan
Bench parameters: DEB_CYCLES=4, HOLD_CYCLES=3, BURST_W=8.
1. Release RESET → `cpu_rst`=1 for exactly 3 cycles, then 0; `cpu_en`=0 throughout; `cycle_count`=0.
2. STEP mode; hold `key_step_n` low for 10 cycles with a 1-cycle glitch high at cycle 2 → exactly one `cpu_en` pulse, `cycle_count`=1. A 3-cycle low blip → no pulse.
3. BURST mode, `burst_len`=5, press → `cpu_en` high for exactly 5 consecutive cycles, `cycle_count`=5. A second press mid-burst is ignored. `burst_len`=0 → no `cpu_en`.
4. RUN mode for 20 cycles, then HALT → `cpu_en` high for 20 cycles, `cycle_count`=20; drops 1 cycle after the mode change.
5. Burst of 200 interrupted after 7 cycles by a 1-cycle `core_rst_req` → `cpu_en` low on the next edge, `cpu_rst` high for 3 cycles, `cycle_count`=0, then IDLE.
6. Preload `cycle_count`=0xFFFFFFFE by force, then RUN for 3 cycles → values 0xFFFFFFFF, 0, 1.
